aes_in_ctrl: RTL and testbench

Synthesizable input controller between the stimulus transmitter (or a host interface) and the AES core. It accepts 257-bit words over a valid/ready handshake; bit 256 tags a word as a key or a data block. Key words are loaded into the core with a one-cycle `key_ld_p` pulse, after which the block waits for key expansion to finish. Data words are issued as 128-bit blocks with a start pulse and a done handshake, and the block back-pressures upstream while the core is busy.

---
 rtl/aes_in_pkg.sv | 22 ++
 rtl/aes_in_tocnt.sv | 33 +++
 rtl/aes_in_ctrl.sv | 112 +++++++++++
 tb/tb_aes_in_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_in_pkg.sv
// Shared definitions for the AES input controller: word layout and FSM states.
package aes_in_pkg;

    localparam int KEY_W   = 256;
    localparam int BLK_W   = 128;
    localparam int WORD_W  = 257;
    localparam int TAG_BIT = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_LD   = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_BLK_ST   = 3'd3,
        ST_BLK_WAIT = 3'd4
    } state_t;

    // True in the two states that wait on a done signal from the core.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_KEY_WAIT) || (s == ST_BLK_WAIT);
    endfunction

endpackage

// File: rtl/aes_in_tocnt.sv
// Timeout counter: cleared to zero, counts while enabled, flags the last
// allowed cycle. TIMEOUT = 0 disables the flag entirely.
module aes_in_tocnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int            LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST   = CW'(LAST_I);

    logic [CW-1:0] cnt;

    // Count waited cycles; hold at the last value so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // High during the final permitted waiting cycle.
    assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/aes_in_ctrl.sv
// AES input controller: takes tagged key/data words from upstream, loads keys
// into the core, issues data blocks and back-pressures while the core works.
//
// Handshake: upstream holds in_data stable while in_vld is high; a word is
// consumed on a rising clk edge where in_vld & in_rdy. in_rdy is high only in
// IDLE and does not depend on in_vld.
module aes_in_ctrl
    import aes_in_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_ld_p,
    input  logic              key_done,
    output logic [BLK_W-1:0]  blk_out,
    output logic              blk_start,
    input  logic              blk_done,
    output logic              key_valid,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic              err_nokey,
    output logic              err_timeout,
    output logic              busy
);

    state_t state;
    logic   to_expired;

    // Pulses and handshake flags are plain decodes of the state register.
    assign in_rdy    = (state == ST_IDLE);
    assign key_ld_p  = (state == ST_KEY_LD);
    assign blk_start = (state == ST_BLK_ST);
    assign busy      = (state != ST_IDLE);

    // The one-cycle pulse states always lead into a wait state, so they clear
    // the counter and the wait starts from zero.
    aes_in_tocnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tocnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (key_ld_p || blk_start),
        .en      (is_wait_state(state)),
        .expired (to_expired)
    );

    // Main FSM with the key/block registers, counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            key_out     <= '0;
            blk_out     <= '0;
            blk_cnt     <= '0;
            key_valid   <= 1'b0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_vld) begin
                        if (in_data[TAG_BIT]) begin
                            key_out   <= in_data[KEY_W-1:0];
                            key_valid <= 1'b0;
                            blk_cnt   <= '0;
                            state     <= ST_KEY_LD;
                        end else if (key_valid) begin
                            blk_out <= in_data[BLK_W-1:0];
                            state   <= ST_BLK_ST;
                        end else begin
                            // No usable key: drop the block and remember it.
                            err_nokey <= 1'b1;
                        end
                    end
                end
                ST_KEY_LD: begin
                    state <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    // Done takes priority over a timeout in the same cycle.
                    if (key_done) begin
                        key_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_BLK_ST: begin
                    blk_cnt <= blk_cnt + CNT_W'(1);
                    state   <= ST_BLK_WAIT;
                end
                ST_BLK_WAIT: begin
                    if (blk_done) begin
                        state <= ST_IDLE;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_in_ctrl.sv
// Bench for aes_in_ctrl: directed key/data sequences, a transaction-level
// model checked every cycle, a blk_out scoreboard and literal spot checks.
module tb_aes_in_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int OP_NONE = 0;
    localparam int OP_KEY  = 1;
    localparam int OP_BLK  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [256:0]       in_data = '0;
    logic               in_vld = 1'b0;
    logic               in_rdy;
    logic [255:0]       key_out;
    logic               key_ld_p;
    logic               key_done = 1'b0;
    logic [127:0]       blk_out;
    logic               blk_start;
    logic               blk_done = 1'b0;
    logic               key_valid;
    logic [CNT_W-1:0]   blk_cnt;
    logic               err_nokey;
    logic               err_timeout;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] exp_q[$];

    aes_in_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .key_out     (key_out),
        .key_ld_p    (key_ld_p),
        .key_done    (key_done),
        .blk_out     (blk_out),
        .blk_start   (blk_start),
        .blk_done    (blk_done),
        .key_valid   (key_valid),
        .blk_cnt     (blk_cnt),
        .err_nokey   (err_nokey),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // m_op: operation in flight; m_w: -1 in the pulse cycle, otherwise the
    // number of cycles already spent waiting for done.
    int           m_op  = OP_NONE;
    int           m_w   = 0;
    logic [255:0] m_key = '0;
    logic [127:0] m_blk = '0;
    int           m_cnt = 0;
    bit           m_kv  = 0;
    bit           m_enk = 0;
    bit           m_eto = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op <= OP_NONE; m_w <= 0; m_key <= '0; m_blk <= '0;
            m_cnt <= 0; m_kv <= 0; m_enk <= 0; m_eto <= 0;
        end else if (m_op == OP_NONE) begin
            if (in_vld) begin
                if (in_data[256]) begin
                    m_key <= in_data[255:0]; m_kv <= 0; m_cnt <= 0;
                    m_op <= OP_KEY; m_w <= -1;
                end else if (m_kv) begin
                    m_blk <= in_data[127:0]; m_op <= OP_BLK; m_w <= -1;
                end else begin
                    m_enk <= 1;
                end
            end
        end else if (m_w < 0) begin
            m_w <= 0;
            if (m_op == OP_BLK) m_cnt <= (m_cnt + 1) % (1 << CNT_W);
        end else if ((m_op == OP_KEY) ? key_done : blk_done) begin
            if (m_op == OP_KEY) m_kv <= 1;
            m_op <= OP_NONE;
        end else if (TIMEOUT != 0 && m_w == TIMEOUT - 1) begin
            m_eto <= 1;
            m_op  <= OP_NONE;
        end else begin
            m_w <= m_w + 1;
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    always @(negedge clk) begin
        chk("in_rdy",      in_rdy,      m_op == OP_NONE);
        chk("busy",        busy,        m_op != OP_NONE);
        chk("key_ld_p",    key_ld_p,    m_op == OP_KEY && m_w < 0);
        chk("blk_start",   blk_start,   m_op == OP_BLK && m_w < 0);
        chk("key_out",     key_out,     m_key);
        chk("blk_out",     blk_out,     m_blk);
        chk("key_valid",   key_valid,   m_kv);
        chk("blk_cnt",     blk_cnt,     m_cnt[CNT_W-1:0]);
        chk("err_nokey",   err_nokey,   m_enk);
        chk("err_timeout", err_timeout, m_eto);
        chk("pulse_overlap", key_ld_p & blk_start, 1'b0);
        if (blk_start) begin
            if (exp_q.size() == 0) chk("blk_start_unexpected", 1'b1, 1'b0);
            else chk("sb_blk_out", blk_out, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_vld = 0; key_done = 0; blk_done = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Returns in the cycle right after the accepting edge.
    task automatic send_word(input logic [256:0] w);
        int guard = 0;
        while (!in_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_rdy) chk("send_rdy_timeout", 1'b0, 1'b1);
        in_data = w;
        in_vld  = 1;
        @(negedge clk);
        in_vld  = 0;
    endtask

    // dly < 0: never return done. lat counts cycles from the accept edge to
    // the cycle in which in_rdy is seen high again.
    task automatic pulse_done(input bit is_key, input int dly, inout int lat);
        if (dly >= 0) begin
            repeat (dly) begin @(negedge clk); lat++; end
            if (is_key) key_done = 1; else blk_done = 1;
            @(negedge clk);
            lat++;
            key_done = 0; blk_done = 0;
        end
        while (!in_rdy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!in_rdy) chk("wait_rdy_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_key(input logic [255:0] k, input int dly, output int lat);
        send_word({1'b1, k});
        lat = 1;
        chk("key_ld_pulse", key_ld_p, 1'b1);
        pulse_done(1'b1, dly, lat);
    endtask

    task automatic do_blk(input logic [127:0] b, input int dly, output int lat);
        exp_q.push_back(b);
        send_word({1'b0, 128'h0, b});
        lat = 1;
        chk("blk_start_pulse", blk_start, 1'b1);
        chk("blk_out_lit", blk_out, b);
        pulse_done(1'b0, dly, lat);
    endtask

    // ---------------- directed sequence ----------------
    logic [255:0] key_a5;
    logic [127:0] blks[3];
    int           lat;

    initial begin
        key_a5  = {32{8'hA5}};
        blks[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        blks[1] = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        blks[2] = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

        do_reset();
        chk("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_blk_cnt", blk_cnt, 0);

        // Key, done from a core that answers four edges after sampling the pulse.
        do_key(key_a5, 5, lat);
        chk("key_rdy_latency", lat, 7);
        chk("key_out_lit", key_out, key_a5);
        chk("key_valid_lit", key_valid, 1'b1);

        // Three back-to-back blocks, done two edges after each start.
        for (int i = 0; i < 3; i++) begin
            do_blk(blks[i], 3, lat);
            chk("blk_rdy_latency", lat, 5);
        end
        chk("blk_cnt_3", blk_cnt, 3);

        // Stray done pulses in IDLE are ignored.
        blk_done = 1; key_done = 1;
        @(negedge clk);
        blk_done = 0; key_done = 0;
        @(negedge clk);
        chk("stray_cnt", blk_cnt, 3);
        chk("stray_busy", busy, 1'b0);

        // Done on the last permitted cycle wins over the timeout.
        do_key(~key_a5, 8, lat);
        chk("coinc_key_lat", lat, 10);
        chk("coinc_key_err", err_timeout, 1'b0);
        chk("coinc_key_valid", key_valid, 1'b1);
        do_blk(blks[1], 8, lat);
        chk("coinc_blk_lat", lat, 10);
        chk("coinc_blk_err", err_timeout, 1'b0);

        // 15 more minimum-turnaround blocks: 16 in total wraps the 4-bit count.
        for (int i = 0; i < 15; i++) begin
            do_blk(128'(i * 32'h01010101 + 7), 1, lat);
            chk("min_blk_lat", lat, 3);
            if (i == 13) chk("cnt_15", blk_cnt, 15);
        end
        chk("cnt_wrap", blk_cnt, 0);

        // Key with no done: timeout after 8 waiting cycles.
        do_key(256'h1234, -1, lat);
        chk("to_lat", lat, 10);
        chk("to_err", err_timeout, 1'b1);
        chk("to_key_valid", key_valid, 1'b0);
        chk("to_key_out", key_out, 256'h1234);

        // Data word with no key after reset is dropped.
        do_reset();
        chk("nokey_pre", err_nokey, 1'b0);
        send_word({1'b0, 128'h0, blks[2]});
        chk("nokey_err", err_nokey, 1'b1);
        chk("nokey_rdy", in_rdy, 1'b1);
        chk("nokey_start", blk_start, 1'b0);
        chk("nokey_cnt", blk_cnt, 0);

        // Reset in the middle of BLK_WAIT.
        do_reset();
        do_key(key_a5, 1, lat);
        exp_q.push_back(blks[0]);
        send_word({1'b0, 128'h0, blks[0]});
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("ar_in_rdy", in_rdy, 1'b1);
        chk("ar_busy", busy, 1'b0);
        chk("ar_key_out", key_out, 0);
        chk("ar_blk_out", blk_out, 0);
        chk("ar_blk_cnt", blk_cnt, 0);
        chk("ar_key_valid", key_valid, 1'b0);
        chk("ar_pulses", {key_ld_p, blk_start}, 0);
        chk("ar_errs", {err_nokey, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_key(~key_a5, 2, lat);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_key", key_out, ~key_a5);
        chk("post_rst_valid", key_valid, 1'b1);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
